// File: rtl/sb_pkg.sv
// sb_pkg: shared types and constants for the write-through store buffer.
//
// Contents:
//   SB_SIZE_B/H/W/R  store size encodings (byte, half, word, reserved)
//   sb_entry_t       one queued store: word address, lane-aligned data,
//                    byte enables
//   sb_state_e       buffer control state (normal running / flushing)
//   sb_byte_be       byte-enable mask for a single byte at a lane offset
package sb_pkg;

    localparam logic [1:0] SB_SIZE_B = 2'b00;
    localparam logic [1:0] SB_SIZE_H = 2'b01;
    localparam logic [1:0] SB_SIZE_W = 2'b10;
    localparam logic [1:0] SB_SIZE_R = 2'b11;

    typedef struct packed {
        logic [29:0] waddr;
        logic [31:0] data;
        logic [3:0]  be;
    } sb_entry_t;

    typedef enum logic {
        SB_RUN   = 1'b0,
        SB_FLUSH = 1'b1
    } sb_state_e;

    function automatic logic [3:0] sb_byte_be(input logic [1:0] offset);
        return 4'b0001 << offset;
    endfunction

endpackage

// File: rtl/store_align.sv
// store_align: purely combinational store alignment.
// Turns a right-justified store value plus size and byte offset into
// lane-aligned data and byte enables, and flags misaligned or reserved
// sizes. Kept separate so the load path can reuse the same lane rules.
//
// Ports:
//   offset     in   2   byte offset within the word (addr[1:0])
//   size       in   2   00 byte, 01 half, 10 word, 11 reserved
//   data       in  32   right-justified store value
//   lane_data  out 32   value moved onto its byte lanes (unused lanes 0)
//   be         out  4   byte enables (0 when err)
//   err        out  1   misaligned access or reserved size
module store_align (
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic [31:0] data,
    output logic [31:0] lane_data,
    output logic [3:0]  be,
    output logic        err
);
    import sb_pkg::*;

    // A rejected store leaves be and lane_data at zero so nothing
    // downstream can mistake it for a real write.
    always_comb begin
        lane_data = '0;
        be        = '0;
        err       = 1'b0;
        unique case (size)
            SB_SIZE_B: begin
                be        = sb_byte_be(offset);
                lane_data = {24'b0, data[7:0]} << {offset, 3'b000};
            end
            SB_SIZE_H: begin
                if (offset[0]) begin
                    err = 1'b1;
                end else if (offset[1]) begin
                    be        = 4'b1100;
                    lane_data = {data[15:0], 16'b0};
                end else begin
                    be        = 4'b0011;
                    lane_data = {16'b0, data[15:0]};
                end
            end
            SB_SIZE_W: begin
                if (offset != 2'b00) begin
                    err = 1'b1;
                end else begin
                    be        = 4'b1111;
                    lane_data = data;
                end
            end
            default: begin
                err = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/store_buffer.sv
// store_buffer: write-through store buffer between the memory stage /
// data cache and the external data memory port.
// Stores are accepted in one cycle into a FIFO of lane-aligned entries and
// drained to memory one at a time over mem_req/mem_ack. Loads probe the
// buffer combinationally and get youngest-wins per-byte forwarding. A flush
// stops new stores until the buffer has fully drained.
//
// Ports:
//   clk, rst_n          clock; asynchronous active-low reset
//   st_valid/st_ready   store handshake
//   st_addr/st_data/st_size  store byte address, right-justified data, size
//   st_err              one-cycle pulse after a misaligned/reserved store
//   ld_addr             load probe address
//   fwd_mask/fwd_data   lanes covered by pending stores and their bytes
//   flush/flush_done    flush request and completion pulse
//   mem_req/mem_ack     memory write handshake
//   mem_addr/mem_wdata/mem_be  head entry (word address, lane data, enables)
//   count               occupied entries
//   drained             stores written to memory since reset (wraps)
//
// Only ADDR_WIDTH = 32 and DATA_WIDTH = 32 are supported.
module store_buffer #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       st_valid,
    output logic                       st_ready,
    input  logic [ADDR_WIDTH-1:0]      st_addr,
    input  logic [DATA_WIDTH-1:0]      st_data,
    input  logic [1:0]                 st_size,
    output logic                       st_err,
    input  logic [ADDR_WIDTH-1:0]      ld_addr,
    output logic [3:0]                 fwd_mask,
    output logic [DATA_WIDTH-1:0]      fwd_data,
    input  logic                       flush,
    output logic                       flush_done,
    output logic                       mem_req,
    output logic [ADDR_WIDTH-1:0]      mem_addr,
    output logic [DATA_WIDTH-1:0]      mem_wdata,
    output logic [3:0]                 mem_be,
    input  logic                       mem_ack,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic [31:0]                drained
);
    import sb_pkg::*;

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    sb_entry_t         fifo_q [DEPTH];
    sb_entry_t         head;
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     fwd_idx;
    sb_state_e         state;

    logic [31:0]       al_data;
    logic [3:0]        al_be;
    logic              al_err;

    logic              full;
    logic              empty;
    logic              enq;
    logic              pop;
    logic              unused_ld_lo;

    store_align u_align (
        .offset    (st_addr[1:0]),
        .size      (st_size),
        .data      (st_data),
        .lane_data (al_data),
        .be        (al_be),
        .err       (al_err)
    );

    // Forwarding works on whole words, so the probe's byte offset is unused.
    assign unused_ld_lo = ^ld_addr[1:0];

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    // st_ready depends only on registered state, never on st_valid.
    assign st_ready = !full && (state == SB_RUN);
    assign enq      = st_valid && st_ready && !al_err;
    assign pop      = mem_ack && !empty;

    // The head entry is presented whenever the buffer is non-empty; the
    // address/data/enables are forced to zero while idle so the port is
    // quiet after reset and between bursts.
    assign head       = fifo_q[rd_ptr];
    assign mem_req    = !empty;
    assign mem_addr   = empty ? '0 : {head.waddr, 2'b00};
    assign mem_wdata  = empty ? '0 : head.data;
    assign mem_be     = empty ? '0 : head.be;

    // Completion is signalled during the cycle the flushing buffer is seen
    // empty; the state returns to RUN on the same edge.
    assign flush_done = (state == SB_FLUSH) && empty;

    // Entry storage has no reset: the pointers and count decide which
    // entries are meaningful.
    always_ff @(posedge clk) begin
        if (enq) begin
            fifo_q[wr_ptr] <= '{waddr: st_addr[31:2], data: al_data, be: al_be};
        end
    end

    // Pointers, occupancy, drain counter and error pulse. Pointers wrap
    // naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            drained <= '0;
            st_err  <= 1'b0;
        end else begin
            st_err <= st_valid && al_err;
            if (enq) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr  <= rd_ptr + PW'(1);
                drained <= drained + 32'd1;
            end
            unique case ({enq, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Control state: a flush request blocks new stores until the buffer is
    // empty; repeated flush requests while flushing have no effect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= SB_RUN;
        end else begin
            unique case (state)
                SB_RUN: begin
                    if (flush) begin
                        state <= SB_FLUSH;
                    end
                end
                SB_FLUSH: begin
                    if (empty) begin
                        state <= SB_RUN;
                    end
                end
                default: state <= SB_RUN;
            endcase
        end
    end

    // Walk the valid entries from oldest to youngest so that a younger
    // matching entry overwrites the lanes of an older one. An entry being
    // acked this cycle is still valid here; one being written this edge is
    // not yet counted.
    always_comb begin
        fwd_mask = '0;
        fwd_data = '0;
        fwd_idx  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            fwd_idx = rd_ptr + PW'(i);
            if ((CW'(i) < count) && (fifo_q[fwd_idx].waddr == ld_addr[31:2])) begin
                for (int l = 0; l < 4; l++) begin
                    if (fifo_q[fwd_idx].be[l]) begin
                        fwd_mask[l]        = 1'b1;
                        fwd_data[l*8 +: 8] = fifo_q[fwd_idx].data[l*8 +: 8];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: self-checking bench for store_buffer.
// A byte-level reference model (queue of pending writes) is kept in the
// bench; the stimulus process drives directed and random traffic while a
// negedge monitor compares every DUT output with the model and retires
// expected memory writes as they are acked.
module tb_store_buffer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        st_valid = 1'b0;
    logic        st_ready;
    logic [31:0] st_addr = '0;
    logic [31:0] st_data = '0;
    logic [1:0]  st_size = '0;
    logic        st_err;
    logic [31:0] ld_addr = '0;
    logic [3:0]  fwd_mask;
    logic [31:0] fwd_data;
    logic        flush = 1'b0;
    logic        flush_done;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack = 1'b0;
    logic [2:0]  count;
    logic [31:0] drained;

    int vectors     = 0;
    int miscompares = 0;

    store_buffer #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .st_valid   (st_valid),
        .st_ready   (st_ready),
        .st_addr    (st_addr),
        .st_data    (st_data),
        .st_size    (st_size),
        .st_err     (st_err),
        .ld_addr    (ld_addr),
        .fwd_mask   (fwd_mask),
        .fwd_data   (fwd_data),
        .flush      (flush),
        .flush_done (flush_done),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_be     (mem_be),
        .mem_ack    (mem_ack),
        .count      (count),
        .drained    (drained)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [29:0] waddr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } exp_t;

    // Reference model state: pending writes oldest-first, flush mode,
    // pending error pulse and drain count.
    exp_t        sb_q[$];
    bit          m_run     = 1'b1;
    bit          m_err     = 1'b0;
    int unsigned m_drained = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Byte-level view of a store: each of the 1/2/4 bytes goes to the lane
    // of its own byte address. Returns 0 when the store must be dropped.
    function automatic bit modelStore(input logic [31:0] addr, input logic [1:0] size,
                                      input logic [31:0] data, output exp_t e);
        int nbytes;
        int lane;
        e.waddr = addr[31:2];
        e.wdata = '0;
        e.be    = '0;
        if (size == 2'b11) return 1'b0;
        nbytes = 1 << size;
        if ((int'(addr[1:0]) % nbytes) != 0) return 1'b0;
        for (int k = 0; k < nbytes; k++) begin
            lane = (int'(addr[1:0]) + k) % 4;
            e.be[lane]          = 1'b1;
            e.wdata[lane*8 +: 8] = data[k*8 +: 8];
        end
        return 1'b1;
    endfunction

    function automatic void modelForward(input logic [31:0] la, output logic [3:0] m,
                                         output logic [31:0] d);
        m = '0;
        d = '0;
        foreach (sb_q[j]) begin
            if (sb_q[j].waddr == la[31:2]) begin
                for (int l = 0; l < 4; l++) begin
                    if (sb_q[j].be[l]) begin
                        m[l]        = 1'b1;
                        d[l*8 +: 8] = sb_q[j].wdata[l*8 +: 8];
                    end
                end
            end
        end
    endfunction

    exp_t        mon_e;
    bit          mon_ok;
    bit          mon_rdy;
    logic [3:0]  mon_m;
    logic [31:0] mon_d;
    int          mon_size;

    // Monitor / scoreboard: compare outputs with the model, then advance the
    // model by what the coming rising edge does (inputs are stable here).
    always @(negedge clk) begin
        if (!rst_n) begin
            sb_q.delete();
            m_run     = 1'b1;
            m_err     = 1'b0;
            m_drained = 0;
            checkOutput("rst_count", 32'(count), 32'd0);
            checkOutput("rst_mem_req", 32'(mem_req), 32'd0);
            checkOutput("rst_mem_be", 32'(mem_be), 32'd0);
            checkOutput("rst_mem_addr", mem_addr, 32'd0);
            checkOutput("rst_mem_wdata", mem_wdata, 32'd0);
            checkOutput("rst_fwd_mask", 32'(fwd_mask), 32'd0);
            checkOutput("rst_fwd_data", fwd_data, 32'd0);
            checkOutput("rst_st_err", 32'(st_err), 32'd0);
            checkOutput("rst_flush_done", 32'(flush_done), 32'd0);
            checkOutput("rst_drained", drained, 32'd0);
        end else begin
            mon_size = sb_q.size();
            mon_rdy  = m_run && (mon_size < 4);
            checkOutput("st_ready", 32'(st_ready), 32'(mon_rdy));
            checkOutput("count", 32'(count), 32'(mon_size));
            checkOutput("mem_req", 32'(mem_req), 32'(mon_size > 0));
            if (mon_size > 0) begin
                checkOutput("mem_addr", mem_addr, {sb_q[0].waddr, 2'b00});
                checkOutput("mem_wdata", mem_wdata, sb_q[0].wdata);
                checkOutput("mem_be", 32'(mem_be), 32'(sb_q[0].be));
            end
            modelForward(ld_addr, mon_m, mon_d);
            checkOutput("fwd_mask", 32'(fwd_mask), 32'(mon_m));
            checkOutput("fwd_data", fwd_data, mon_d);
            checkOutput("st_err", 32'(st_err), 32'(m_err));
            checkOutput("flush_done", 32'(flush_done), 32'(!m_run && (mon_size == 0)));
            checkOutput("drained", drained, m_drained);

            mon_ok = modelStore(st_addr, st_size, st_data, mon_e);
            m_err  = st_valid && !mon_ok;
            if (mem_ack && (mon_size > 0)) begin
                void'(sb_q.pop_front());
                m_drained++;
            end
            if (st_valid && mon_rdy && mon_ok) begin
                sb_q.push_back(mon_e);
            end
            if (m_run && flush) begin
                m_run = 1'b0;
            end else if (!m_run && (mon_size == 0)) begin
                m_run = 1'b1;
            end
        end
    end

    // One cycle of stimulus: called just after a rising edge, returns just
    // after the next one.
    task automatic applyStimulus(input bit v, input logic [31:0] a, input logic [1:0] sz,
                                 input logic [31:0] d, input bit ack, input logic [31:0] la,
                                 input bit fl);
        st_valid = v;
        st_addr  = a;
        st_size  = sz;
        st_data  = d;
        mem_ack  = ack;
        ld_addr  = la;
        flush    = fl;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input bit ack, input logic [31:0] la);
        applyStimulus(1'b0, 32'h0, 2'b00, 32'h0, ack, la, 1'b0);
    endtask

    task automatic drainAll();
        int c;
        c = 0;
        while ((count != 0) && (c < 40)) begin
            idle(1'b1, 32'h0);
            c++;
        end
        if (count != 0) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL drain_timeout: got count %0d expected 0", count);
        end
        idle(1'b0, 32'h0);
        idle(1'b0, 32'h0);
    endtask

    bit flushSeen;
    int fdPulses;

    initial begin
        // Reset
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        checkOutput("post_reset_ready", 32'(st_ready), 32'd1);

        // Byte store at 0x103 lands on lane 3
        applyStimulus(1'b1, 32'h103, 2'b00, 32'hAB, 1'b1, 32'h0, 1'b0);
        checkOutput("t1_mem_req", 32'(mem_req), 32'd1);
        checkOutput("t1_mem_addr", mem_addr, 32'h100);
        checkOutput("t1_mem_be", 32'(mem_be), 32'h8);
        checkOutput("t1_mem_wdata", mem_wdata, 32'hAB000000);
        idle(1'b1, 32'h0);
        checkOutput("t1_drained", drained, 32'd1);

        // Fill to capacity with memory stalled
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 32'h300 + 32'(4*i), 2'b10, $urandom, 1'b0, 32'h300, 1'b0);
        end
        checkOutput("full_count", 32'(count), 32'd4);
        checkOutput("full_ready", 32'(st_ready), 32'd0);
        applyStimulus(1'b1, 32'h310, 2'b10, 32'hDEAD0001, 1'b0, 32'h300, 1'b0);
        checkOutput("full_reject", 32'(count), 32'd4);
        applyStimulus(1'b1, 32'h314, 2'b10, 32'hDEAD0002, 1'b1, 32'h300, 1'b0);
        checkOutput("ack_pop_count", 32'(count), 32'd3);
        applyStimulus(1'b1, 32'h314, 2'b10, 32'hDEAD0002, 1'b0, 32'h314, 1'b0);
        checkOutput("refill_count", 32'(count), 32'd4);
        drainAll();

        // Youngest byte wins over older word
        applyStimulus(1'b1, 32'h200, 2'b10, 32'h11223344, 1'b0, 32'h200, 1'b0);
        applyStimulus(1'b1, 32'h201, 2'b00, 32'h000000FF, 1'b0, 32'h200, 1'b0);
        checkOutput("fwd_word_mask", 32'(fwd_mask), 32'hF);
        checkOutput("fwd_word_data", fwd_data, 32'h1122FF44);
        drainAll();

        // Misaligned half and reserved size
        applyStimulus(1'b1, 32'h101, 2'b01, 32'h5555, 1'b0, 32'h0, 1'b0);
        checkOutput("mis_half_err", 32'(st_err), 32'd1);
        checkOutput("mis_half_count", 32'(count), 32'd0);
        applyStimulus(1'b1, 32'h100, 2'b11, 32'h5555, 1'b0, 32'h0, 1'b0);
        checkOutput("rsv_size_err", 32'(st_err), 32'd1);
        checkOutput("rsv_size_count", 32'(count), 32'd0);
        idle(1'b0, 32'h0);
        checkOutput("err_single_pulse", 32'(st_err), 32'd0);

        // Flush with three entries pending, memory acking every other cycle
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 32'h400 + 32'(4*i), 2'b10, $urandom, 1'b0, 32'h400, 1'b0);
        end
        applyStimulus(1'b0, 32'h0, 2'b00, 32'h0, 1'b0, 32'h400, 1'b1);
        flushSeen = 1'b0;
        fdPulses  = 0;
        for (int c = 0; c < 40; c++) begin
            checkOutput("flush_ready", 32'(st_ready), 32'd0);
            if (flush_done) fdPulses++;
            if (count == 0) begin
                flushSeen = 1'b1;
                break;
            end
            applyStimulus(1'b1, 32'h480, 2'b10, $urandom, c[0], 32'h400, 1'b1);
        end
        if (!flushSeen) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL flush_timeout: got count %0d expected 0", count);
        end
        idle(1'b0, 32'h0);
        if (flush_done) fdPulses++;
        checkOutput("flush_pulses", 32'(fdPulses), 32'd1);
        checkOutput("flush_back_run", 32'(st_ready), 32'd1);

        // Flush when already empty
        applyStimulus(1'b0, 32'h0, 2'b00, 32'h0, 1'b0, 32'h0, 1'b1);
        checkOutput("empty_flush_done", 32'(flush_done), 32'd1);
        idle(1'b0, 32'h0);
        checkOutput("empty_flush_end", 32'(flush_done), 32'd0);
        checkOutput("empty_flush_ready", 32'(st_ready), 32'd1);

        // Random traffic in a small window so forwarding hits often
        for (int c = 0; c < 1500; c++) begin
            applyStimulus(1'($urandom_range(0, 1)),
                          32'h500 + 32'($urandom_range(0, 15)),
                          2'($urandom_range(0, 3)),
                          $urandom,
                          1'($urandom_range(0, 1)),
                          32'h500 + 32'($urandom_range(0, 15)),
                          ($urandom_range(0, 63) == 0));
        end
        drainAll();

        // Reset in the middle of a handshake
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 32'h600 + 32'(4*i), 2'b10, $urandom, 1'b0, 32'h600, 1'b0);
        end
        checkOutput("pre_rst_count", 32'(count), 32'd3);
        checkOutput("pre_rst_req", 32'(mem_req), 32'd1);
        checkOutput("pre_rst_fwd", 32'(fwd_mask), 32'hF);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_req", 32'(mem_req), 32'd0);
        checkOutput("mid_rst_count", 32'(count), 32'd0);
        checkOutput("mid_rst_fwd", 32'(fwd_mask), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        checkOutput("rel_rst_ready", 32'(st_ready), 32'd1);
        idle(1'b0, 32'h0);
        idle(1'b0, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/store_buffer.md
# store_buffer

Write-through store buffer between the core's memory stage / two-way data cache and the external data memory port. Stores are accepted in one cycle, queued in a FIFO of byte-lane-aligned entries, and drained to memory one at a time over a req/ack handshake, so the cache never stalls on a slow memory write. Loads probe the buffer combinationally and receive youngest-wins byte forwarding of pending stores. A flush sequence empties the buffer before fences or memory-mapped I/O.

## Interface
- ADDR_WIDTH, 32, byte-address width
- DATA_WIDTH, 32, data width (4 byte lanes; only 32 is supported)
- DEPTH, 4, FIFO entries (power of two, ≥2)
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- st_valid  in  1  store request
- st_ready  out  1  store accepted this edge if st_valid
- st_addr  in  ADDR_WIDTH  store byte address
- st_data  in  DATA_WIDTH  store data, right-justified (byte in [7:0], half in [15:0])
- st_size  in  2  00 byte, 01 half, 10 word, 11 reserved
- st_err  out  1  one-cycle pulse: misaligned/reserved store dropped
- ld_addr  in  ADDR_WIDTH  load probe address
- fwd_mask  out  4  byte lanes of ld_addr's word covered by pending stores
- fwd_data  out  DATA_WIDTH  forwarded lanes (uncovered lanes 0)
- flush  in  1  begin flush
- flush_done  out  1  one-cycle pulse when flush completes
- mem_req  out  1  write request to data memory
- mem_addr  out  ADDR_WIDTH  word-aligned address ([1:0]=00)
- mem_wdata  out  DATA_WIDTH  lane-aligned data
- mem_be  out  4  byte enables
- mem_ack  in  1  memory accepted current request
- count  out  $clog2(DEPTH+1)  occupied entries
- drained  out  32  stores written to memory since reset (wraps)

## Operation
- Alignment: byte → lane addr[1:0], be=0001<<addr[1:0]; half requires addr[0]=0, lanes {addr[1],x}, be 0011 or 1100; word requires addr[1:0]=00, be 1111. Violations or size 11: no enqueue, st_err pulses next cycle, regardless of st_ready.
- Enqueue: st_valid & st_ready & aligned → entry {addr[31:2], data, be} written at tail; count+1.
- st_ready = !full & state==RUN. No enqueue when full even if mem_ack the same cycle.
- Drain: mem_req = !empty; mem_addr/wdata/be = head entry; held stable while mem_req & !mem_ack. mem_ack with mem_req pops head at that edge; drained+1. mem_ack without mem_req ignored.
- Simultaneous enqueue and pop: count unchanged; pointers both advance modulo DEPTH.
- Forwarding: combinational over all valid entries with addr match on [31:2]; per lane, youngest matching entry supplies the byte. Head entry being acked this cycle still forwards. Entry enqueued this edge is not visible until next cycle.
- FSM: RUN → FLUSH on flush (st_ready=0 in FLUSH); FLUSH → RUN when count==0, pulsing flush_done in the transition cycle. flush when already empty: flush_done pulses the next cycle. flush asserted during FLUSH ignored.

## Timing
- Reset (async assert, sync-released by caller): count=0, pointers=0, state=RUN, mem_req=0, mem_be=0, mem_addr=0, mem_wdata=0, fwd_mask=0, fwd_data=0, st_err=0, flush_done=0, drained=0; st_ready=1 after reset. Reset mid-handshake abandons the request; memory must tolerate mem_req dropping.
- Store-to-mem_req latency: 1 cycle (enqueue at edge N, mem_req high after N if previously empty).
- Throughput: one drain per cycle with mem_ack held high; one enqueue per cycle.
- Outputs fwd_*, st_ready, mem_* are combinational from registered state and ld_addr; no comb path st_valid→st_ready or mem_ack→mem_req.

## Structure
- Package sb_pkg: size encodings (SB_SIZE_B/H/W), sb_entry_t {logic [29:0] waddr; logic [31:0] data; logic [3:0] be;}, state enum {SB_RUN, SB_FLUSH}.
- Sub-module store_align: combinational size/offset → (aligned data, be, err); reused by the load path later.
- FIFO storage, pointers, FSM and forwarding stay in store_buffer.

## Test plan
- Byte store addr 0x103, data 0xAB, mem_ack tied 1 → next cycle mem_req=1, mem_addr=0x100, mem_be=1000, mem_wdata=0xAB000000; drained=1 after ack.
- Fill 4 word stores with mem_ack=0 → count=4, st_ready=0; 5th st_valid not accepted; one ack + new store same cycle → count 3 then 4, no loss, order preserved.
- Word 0x11223344 @0x200 then byte 0xFF @0x201, probe ld_addr 0x200 → fwd_mask=1111, fwd_data=0x1122FF44.
- Half store addr 0x101 → st_err pulse, count unchanged; size 11 → same.
- 3 entries pending, flush, ack every other cycle → st_ready=0 throughout, flush_done single pulse on the cycle count reaches 0, state back to RUN.
- rst_n low while mem_req=1 and count=3 → immediately mem_req=0, count=0, fwd_mask=0; after release st_ready=1.
